// File: rtl/tinyproc_mem_pkg.sv
// Shared types and defaults for the tinyproc memory port arbiter.
package tinyproc_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: ptr names the requester that wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       next_ptr
);

    always_comb begin
        gnt      = 2'b00;
        next_ptr = ptr;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
            // Only a contended grant moves the pointer; a lone requester keeps winning.
            if (advance) begin
                next_ptr = ~ptr;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the tinyproc memory between fetch (port 0) and load/store (port 1).
// Optional DUAL_READ_EN grants two concurrent reads via the memory's A and B read ports.
module mem_port_arbiter
    import tinyproc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_ra,
    output logic [ADDR_W-1:0] mem_rb,
    output logic [ADDR_W-1:0] mem_rc,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_a,
    input  logic [DATA_W-1:0] mem_data_b
);

    state_t      state;
    logic        rr_ptr;
    logic        op_kind;
    logic [1:0]  op_port;

    logic [1:0]        req_c;
    logic [1:0]        gnt_c;
    logic [1:0]        take_c;
    logic              next_ptr_c;
    logic              advance_c;
    logic              dual_c;
    logic              sel1_c;
    logic              kind_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] rd1_c;

    assign req_c = {p1_valid, p0_valid};

`ifdef DUAL_READ_EN
    assign dual_c = p0_valid & p1_valid & (p0_write == OP_READ) & (p1_write == OP_READ);
    assign rd1_c  = (op_port == 2'b11) ? mem_data_b : mem_data_a;
`else
    logic unused_data_b;
    assign dual_c        = 1'b0;
    assign rd1_c         = mem_data_a;
    assign unused_data_b = ^mem_data_b;
`endif

    assign advance_c = (state == IDLE) & ~dual_c;

    rr_arb2 u_arb (
        .req      (req_c),
        .ptr      (rr_ptr),
        .advance  (advance_c),
        .gnt      (gnt_c),
        .next_ptr (next_ptr_c)
    );

    // Grant is combinational and only offered in IDLE outside reset.
    assign take_c   = ((state == IDLE) && !rst) ? (dual_c ? 2'b11 : gnt_c) : 2'b00;
    assign p0_ready = take_c[0];
    assign p1_ready = take_c[1];

    assign sel1_c  = gnt_c[1] & ~dual_c;
    assign kind_c  = sel1_c ? p1_write : p0_write;
    assign addr_c  = sel1_c ? p1_addr  : p0_addr;
    assign wdata_c = sel1_c ? p1_wdata : p0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            op_kind   <= OP_READ;
            op_port   <= 2'b00;
            mem_ra    <= '0;
            mem_rb    <= '0;
            mem_rc    <= '0;
            mem_write <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|take_c) begin
                        state     <= ISSUE;
                        rr_ptr    <= next_ptr_c;
                        op_kind   <= kind_c;
                        op_port   <= take_c;
                        // Memory writes take their data through RA, address through RC.
                        mem_ra    <= (kind_c == OP_WRITE) ? ADDR_W'(wdata_c) : addr_c;
                        mem_rc    <= (kind_c == OP_WRITE) ? addr_c : '0;
                        mem_rb    <= dual_c ? p1_addr : '0;
                        mem_write <= (kind_c == OP_WRITE);
                    end
                end
                ISSUE: begin
                    state     <= RESP;
                    mem_ra    <= '0;
                    mem_rb    <= '0;
                    mem_rc    <= '0;
                    mem_write <= 1'b0;
                    if (op_port[0]) begin
                        p0_rvalid <= 1'b1;
                        p0_rdata  <= (op_kind == OP_READ) ? mem_data_a : '0;
                    end
                    if (op_port[1]) begin
                        p1_rvalid <= 1'b1;
                        p1_rdata  <= (op_kind == OP_READ) ? rd1_c : '0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    p0_rvalid <= 1'b0;
                    p1_rvalid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_write, p0_ready, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_write, p1_ready, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [31:0] mem_ra, mem_rb, mem_rc, mem_data_a, mem_data_b;
    logic        mem_write;

    logic [31:0] mem_model [16];

    int checks = 0;
    int errors = 0;
    int gseq [4];
    int gi;
    int nrv;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .p0_valid   (p0_valid),
        .p0_write   (p0_write),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_ready   (p0_ready),
        .p0_rvalid  (p0_rvalid),
        .p0_rdata   (p0_rdata),
        .p1_valid   (p1_valid),
        .p1_write   (p1_write),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_ready   (p1_ready),
        .p1_rvalid  (p1_rvalid),
        .p1_rdata   (p1_rdata),
        .mem_ra     (mem_ra),
        .mem_rb     (mem_rb),
        .mem_rc     (mem_rc),
        .mem_write  (mem_write),
        .mem_data_a (mem_data_a),
        .mem_data_b (mem_data_b)
    );

    // Memory: combinational reads, write mem[RC] <= RA on the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_model[i] <= (i == 2) ? 32'h0000_0022 : 32'h0;
        end else if (mem_write && mem_rc < 32'd16) begin
            mem_model[mem_rc[3:0]] <= mem_ra;
        end
    end
    assign mem_data_a = (mem_ra < 32'd16) ? mem_model[mem_ra[3:0]] : 32'h0;
    assign mem_data_b = (mem_rb < 32'd16) ? mem_model[mem_rb[3:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        p0_valid = 1'b1; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset state, with a request pending that must not be granted
        @(negedge clk); @(negedge clk); #1;
        chk("rst_p0_ready", p0_ready, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_ra", mem_ra, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        p0_valid = 1'b0;

        // p1 write 0x00F00F01 to 0x1
        @(negedge clk); rst = 1'b0;
        p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 32'h1; p1_wdata = 32'h00F0_0F01;
        #1;
        chk("wr_p1_ready", p1_ready, 1);
        chk("wr_p0_ready", p0_ready, 0);
        @(negedge clk); p1_valid = 1'b0; #1;
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_rc", mem_rc, 32'h1);
        chk("wr_mem_ra", mem_ra, 32'h00F0_0F01);
        chk("wr_issue_ready", p1_ready, 0);
        @(negedge clk); #1;
        chk("wr_p1_rvalid", p1_rvalid, 1);
        chk("wr_p1_rdata", p1_rdata, 0);
        chk("wr_resp_mem_write", mem_write, 0);
        @(negedge clk); #1;
        chk("wr_rvalid_pulse", p1_rvalid, 0);

        // p0 read 0x1 returns the written data
        p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 32'h1; #1;
        chk("rd_p0_ready", p0_ready, 1);
        @(negedge clk); p0_valid = 1'b0; #1;
        chk("rd_mem_ra", mem_ra, 32'h1);
        chk("rd_mem_write", mem_write, 0);
        @(negedge clk); #1;
        chk("rd_p0_rvalid", p0_rvalid, 1);
        chk("rd_p0_rdata", p0_rdata, 32'h00F0_0F01);
        chk("rd_p1_rvalid", p1_rvalid, 0);

        // Both read, held for 12 cycles
        @(negedge clk);
        p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 32'h1;
        p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 32'h2;
        gi = 0; nrv = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (p0_ready || p1_ready) begin
                if (gi < 4) gseq[gi] = p1_ready ? 1 : 0;
                gi++;
            end
            nrv += int'(p0_rvalid) + int'(p1_rvalid);
            @(negedge clk);
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        chk("rr_grants", 32'(gi), 4);
`ifdef DUAL_READ_EN
        chk("dual_rvalids", 32'(nrv), 8);
`else
        chk("rr_rvalids", 32'(nrv), 4);
        chk("rr_g0", 32'(gseq[0]), 0);
        chk("rr_g1", 32'(gseq[1]), 1);
        chk("rr_g2", 32'(gseq[2]), 0);
        chk("rr_g3", 32'(gseq[3]), 1);
`endif
        chk("rr_p0_rdata", p0_rdata, 32'h00F0_0F01);
        chk("rr_p1_rdata", p1_rdata, 32'h0000_0022);

        // p0 read 0x2 vs p1 write 0x2: rr_ptr=0 so the read goes first
        p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 32'h2;
        p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 32'h2; p1_wdata = 32'h00AA_AA02;
        #1;
        chk("race_p0_ready", p0_ready, 1);
        chk("race_p1_ready", p1_ready, 0);
        @(negedge clk); p0_valid = 1'b0;
        @(negedge clk); #1;
        chk("race_p0_rvalid", p0_rvalid, 1);
        chk("race_p0_old", p0_rdata, 32'h0000_0022);
        @(negedge clk); #1;
        chk("race_p1_ready", p1_ready, 1);
        @(negedge clk); p1_valid = 1'b0; #1;
        chk("race_mem_write", mem_write, 1);
        chk("race_mem_rc", mem_rc, 32'h2);
        @(negedge clk); #1;
        chk("race_p1_rvalid", p1_rvalid, 1);
        @(negedge clk);
        p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 32'h2; #1;
        chk("reread_ready", p0_ready, 1);
        @(negedge clk); p0_valid = 1'b0;
        @(negedge clk); #1;
        chk("reread_rvalid", p0_rvalid, 1);
        chk("reread_rdata", p0_rdata, 32'h00AA_AA02);

        // Reset during ISSUE of a write (rr_ptr is 1 at this point)
        @(negedge clk);
        p0_valid = 1'b1; p0_write = 1'b1; p0_addr = 32'h3; p0_wdata = 32'h33; #1;
        chk("abort_ready", p0_ready, 1);
        @(negedge clk); p0_valid = 1'b0; p0_write = 1'b0; #1;
        chk("abort_issue_write", mem_write, 1);
        #1 rst = 1'b1; #1;
        chk("abort_write_drop", mem_write, 0);
        chk("abort_rc_clear", mem_rc, 0);
        @(negedge clk); rst = 1'b0;
        nrv = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nrv += int'(p0_rvalid) + int'(p1_rvalid);
            @(negedge clk);
        end
        chk("abort_no_rvalid", 32'(nrv), 0);
        p0_valid = 1'b1; p0_write = 1'b1; p0_addr = 32'h5; p0_wdata = 32'h55;
        p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 32'h1;
        #1;
        chk("post_rst_p0_wins", p0_ready, 1);
        chk("post_rst_p1_wait", p1_ready, 0);
        @(negedge clk); p0_valid = 1'b0; p1_valid = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_rvalid", p0_rvalid, 1);
        chk("post_rst_rdata", p0_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
